sdp_ram: RTL and testbench

SDP_RAM -- requirements
Module: sdp_ram

---
 rtl/sdp_ram_pkg.sv | 13 +
 rtl/sdp_ram_core.sv | 38 +++
 rtl/sdp_ram.sv | 145 ++++++++++++++
 tb/tb_sdp_ram.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared types for the simple dual-port RAM: sweep FSM states and byte-lane count helper.
package sdp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int be_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Registered-read simple dual-port array with byte-enable writes; read-first, no reset (block-RAM style).
// 1-cycle read latency; output holds while i_re is low.
module sdp_ram_core
    import sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                            i_clk,
    input  logic                            i_we,
    input  logic [ADDR_WIDTH-1:0]           i_waddr,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    input  logic [be_count(DATA_WIDTH)-1:0] i_wbe,
    input  logic                            i_re,
    input  logic [ADDR_WIDTH-1:0]           i_raddr,
    output logic [DATA_WIDTH-1:0]           o_rdata
);

    localparam int NB    = be_count(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_we && i_wbe[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sdp_ram.sv
// Byte-enable SDP RAM with post-reset zero sweep, write-first collision merge and optional oce-gated output register.
// Read latency 1 (OUT_REG=0) or 1 + wait-for-oce (OUT_REG=1); no backpressure, an unconsumed stage-1 word is overwritten.
module sdp_ram
    import sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [be_count(DATA_WIDTH)-1:0] wr_be,
    input  logic                            rd_en,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic                            oce,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_valid,
    output logic                            busy
);

    localparam int     NB     = be_count(DATA_WIDTH);
    localparam state_e ST_RST = (INIT_CLEAR != 0) ? CLEAR : READY;

    state_e                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  w_wr_acc, w_rd_acc, w_consume;
    logic                  w_core_we;
    logic [ADDR_WIDTH-1:0] w_core_waddr;
    logic [DATA_WIDTH-1:0] w_core_wdata, w_core_rdata, w_s1_data, r_col_data;
    logic [NB-1:0]         w_core_wbe, r_col_be;
    logic                  r_s1_vld, r_s1_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RST;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == CLEAR && r_clr_cnt == '1) begin
            w_state_nxt = READY;
        end
    end

    // While sweeping, the write port belongs to the clear counter and user traffic is dropped.
    always_comb begin
        busy         = (r_state == CLEAR);
        w_wr_acc     = (r_state == READY) && wr_en;
        w_rd_acc     = (r_state == READY) && rd_en;
        w_core_we    = w_wr_acc;
        w_core_waddr = wr_addr;
        w_core_wdata = wr_data;
        w_core_wbe   = wr_be;
        if (r_state == CLEAR) begin
            w_core_we    = 1'b1;
            w_core_waddr = r_clr_cnt;
            w_core_wdata = '0;
            w_core_wbe   = '1;
        end
    end

    sdp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .i_clk   (clk),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_wbe   (w_core_wbe),
        .i_re    (w_rd_acc),
        .i_raddr (rd_addr),
        .o_rdata (w_core_rdata)
    );

    // The core reads old contents; remember colliding write bytes and overlay them after the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_be   <= '0;
            r_col_data <= '0;
            r_s1_seen  <= 1'b0;
        end else if (w_rd_acc) begin
            r_col_be   <= (w_wr_acc && wr_addr == rd_addr) ? wr_be : '0;
            r_col_data <= wr_data;
            r_s1_seen  <= 1'b1;
        end
    end

    always_comb begin
        w_s1_data = '0;
        for (int b = 0; b < NB; b++) begin
            w_s1_data[8*b +: 8] = r_col_be[b] ? r_col_data[8*b +: 8] : w_core_rdata[8*b +: 8];
        end
        if (!r_s1_seen) begin
            w_s1_data = '0;
        end
    end

    assign w_consume = (OUT_REG != 0) ? oce : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_rd_acc | (r_s1_vld & ~w_consume);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= oce & r_s1_vld;
                    if (oce && r_s1_vld) begin
                        r_rd_data <= w_s1_data;
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end else begin : g_no_out_reg
            assign rd_data  = w_s1_data;
            assign rd_valid = r_s1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram.sv
// Directed bench for sdp_ram: default config (sweep, collisions, mid-sweep reset), 32-bit byte enables, and oce-gated output register.
module tb_sdp_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Instance A: defaults (8-bit, 2048 deep, OUT_REG=0, INIT_CLEAR=1)
    logic        a_rst = 1'b1, a_wr_en = 1'b0, a_rd_en = 1'b0, a_oce = 1'b0;
    logic [10:0] a_wr_addr = '0, a_rd_addr = '0;
    logic [7:0]  a_wr_data = '0, a_rd_data;
    logic [0:0]  a_wr_be = '0;
    logic        a_rd_valid, a_busy;

    sdp_ram u_a (
        .clk (clk), .rst (a_rst), .wr_en (a_wr_en), .wr_addr (a_wr_addr), .wr_data (a_wr_data),
        .wr_be (a_wr_be), .rd_en (a_rd_en), .rd_addr (a_rd_addr), .oce (a_oce),
        .rd_data (a_rd_data), .rd_valid (a_rd_valid), .busy (a_busy)
    );

    // Instance B: 32-bit words, 16 deep, no clear sweep
    logic        b_rst = 1'b1, b_wr_en = 1'b0, b_rd_en = 1'b0, b_oce = 1'b0;
    logic [3:0]  b_wr_addr = '0, b_rd_addr = '0, b_wr_be = '0;
    logic [31:0] b_wr_data = '0, b_rd_data;
    logic        b_rd_valid, b_busy;

    sdp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .INIT_CLEAR(0)) u_b (
        .clk (clk), .rst (b_rst), .wr_en (b_wr_en), .wr_addr (b_wr_addr), .wr_data (b_wr_data),
        .wr_be (b_wr_be), .rd_en (b_rd_en), .rd_addr (b_rd_addr), .oce (b_oce),
        .rd_data (b_rd_data), .rd_valid (b_rd_valid), .busy (b_busy)
    );

    // Instance C: 8-bit, 16 deep, output register gated by oce
    logic        c_rst = 1'b1, c_wr_en = 1'b0, c_rd_en = 1'b0, c_oce = 1'b0;
    logic [3:0]  c_wr_addr = '0, c_rd_addr = '0;
    logic [7:0]  c_wr_data = '0, c_rd_data;
    logic [0:0]  c_wr_be = '0;
    logic        c_rd_valid, c_busy;

    sdp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(1), .INIT_CLEAR(1)) u_c (
        .clk (clk), .rst (c_rst), .wr_en (c_wr_en), .wr_addr (c_wr_addr), .wr_data (c_wr_data),
        .wr_be (c_wr_be), .rd_en (c_rd_en), .rd_addr (c_rd_addr), .oce (c_oce),
        .rd_data (c_rd_data), .rd_valid (c_rd_valid), .busy (c_busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [10:0] addr, input logic [7:0] d, input logic be);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = d; a_wr_be = be;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic a_read(input string tag, input logic [10:0] addr, input logic [7:0] exp);
        a_rd_en = 1'b1; a_rd_addr = addr;
        tick();
        a_rd_en = 1'b0;
        check({tag, "_vld"}, 32'(a_rd_valid), 32'd1);
        check(tag, 32'(a_rd_data), 32'(exp));
    endtask

    task automatic a_sweep_len(output int n);
        n = 0;
        while (a_busy === 1'b1 && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = d; b_wr_be = be;
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic b_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        b_rd_en = 1'b1; b_rd_addr = addr;
        tick();
        b_rd_en = 1'b0;
        check({tag, "_vld"}, 32'(b_rd_valid), 32'd1);
        check(tag, b_rd_data, exp);
    endtask

    task automatic c_write(input logic [3:0] addr, input logic [7:0] d);
        c_wr_en = 1'b1; c_wr_addr = addr; c_wr_data = d; c_wr_be = 1'b1;
        tick();
        c_wr_en = 1'b0;
    endtask

    initial begin
        int n;
        int v;

        tick();
        tick();
        check("a_rst_busy", 32'(a_busy), 32'd1);
        check("a_rst_vld", 32'(a_rd_valid), 32'd0);
        check("a_rst_data", 32'(a_rd_data), 32'd0);
        check("b_rst_busy", 32'(b_busy), 32'd0);
        check("c_rst_busy", 32'(c_busy), 32'd1);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // First sweep on A, with user traffic to address 5 that must be ignored
        n = 0; v = 0;
        while (a_busy === 1'b1 && n < 5000) begin
            a_wr_en = (n >= 10 && n < 2000); a_wr_addr = 11'd5; a_wr_data = 8'hFF; a_wr_be = 1'b1;
            a_rd_en = (n >= 10 && n < 2000); a_rd_addr = 11'd5;
            tick();
            n++;
            if (a_rd_valid === 1'b1) v++;
        end
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        check("a_sweep_len", 32'(n), 32'd2048);
        check("a_busy_vld", 32'(v), 32'd0);
        check("c_busy_done", 32'(c_busy), 32'd0);

        a_read("a_rd0", 11'd0, 8'h00);
        a_read("a_rd1023", 11'd1023, 8'h00);
        a_read("a_rd2047", 11'd2047, 8'h00);
        tick();
        check("a_vld_pulse", 32'(a_rd_valid), 32'd0);
        a_read("a_rd5_busy_wr", 11'd5, 8'h00);

        // Same-cycle write/read on address 7: write-first
        a_wr_en = 1'b1; a_wr_addr = 11'd7; a_wr_data = 8'h5A; a_wr_be = 1'b1;
        a_read("a_collide7", 11'd7, 8'h5A);
        a_wr_en = 1'b0;
        // Different addresses in the same cycle are independent
        a_wr_en = 1'b1; a_wr_addr = 11'd8; a_wr_data = 8'h33; a_wr_be = 1'b1;
        a_read("a_indep7", 11'd7, 8'h5A);
        a_wr_en = 1'b0;
        a_read("a_rd8", 11'd8, 8'h33);
        a_write(11'd7, 8'h99, 1'b0);
        a_read("a_be0", 11'd7, 8'h5A);
        tick();
        tick();
        check("a_hold_data", 32'(a_rd_data), 32'h5A);
        check("a_hold_vld", 32'(a_rd_valid), 32'd0);

        // Reset in the middle of a sweep restarts from address 0
        a_write(11'd600, 8'hFF, 1'b1);
        a_read("a_rd600_ff", 11'd600, 8'hFF);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        repeat (500) tick();
        a_rst = 1'b1;
        #1;
        check("a_midrst_busy", 32'(a_busy), 32'd1);
        check("a_midrst_data", 32'(a_rd_data), 32'd0);
        tick();
        a_rst = 1'b0;
        a_sweep_len(n);
        check("a_resweep_len", 32'(n), 32'd2048);
        a_read("a_rd600_clr", 11'd600, 8'h00);

        // B: 32-bit byte enables
        b_write(4'd3, 32'hAABBCCDD, 4'b1111);
        b_write(4'd3, 32'h11223344, 4'b0101);
        b_read("b_be_merge", 4'd3, 32'hAA22CC44);
        b_wr_en = 1'b1; b_wr_addr = 4'd3; b_wr_data = 32'h55667788; b_wr_be = 4'b1000;
        b_read("b_collide_part", 4'd3, 32'h5522CC44);
        b_wr_en = 1'b0;
        b_read("b_after_coll", 4'd3, 32'h5522CC44);

        // C: output register gated by oce
        c_write(4'd2, 8'h3C);
        c_write(4'd4, 8'h44);
        c_oce = 1'b0; c_rd_en = 1'b1; c_rd_addr = 4'd2;
        tick();
        c_rd_en = 1'b0;
        v = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (c_rd_valid === 1'b1) v++;
        end
        check("c_wait_vld", 32'(v), 32'd0);
        check("c_wait_data", 32'(c_rd_data), 32'd0);
        c_oce = 1'b1;
        tick();
        check("c_oce_vld", 32'(c_rd_valid), 32'd1);
        check("c_oce_data", 32'(c_rd_data), 32'h3C);
        tick();
        check("c_oce_pulse", 32'(c_rd_valid), 32'd0);
        check("c_oce_hold", 32'(c_rd_data), 32'h3C);

        // Unconsumed stage-1 word is overwritten by a newer read
        c_oce = 1'b0; c_rd_en = 1'b1; c_rd_addr = 4'd2;
        tick();
        c_rd_addr = 4'd4;
        tick();
        c_rd_en = 1'b0; c_oce = 1'b1;
        tick();
        check("c_ovr_vld", 32'(c_rd_valid), 32'd1);
        check("c_ovr_data", 32'(c_rd_data), 32'h44);
        tick();
        check("c_ovr_single", 32'(c_rd_valid), 32'd0);

        // Streaming with oce held high: two-cycle latency
        c_rd_en = 1'b1; c_rd_addr = 4'd2;
        tick();
        c_rd_en = 1'b0;
        check("c_pipe_n", 32'(c_rd_valid), 32'd0);
        tick();
        check("c_pipe_n1_vld", 32'(c_rd_valid), 32'd1);
        check("c_pipe_n1_data", 32'(c_rd_data), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
